// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and the slave state enumeration shared by slave_ahb and master_ahb.
package ahb_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Little-endian byte-lane enables for a legal (aligned) transfer.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << addr;
            HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/slave_mem.sv
// Word-organised storage for slave_ahb: byte-enable synchronous write, combinational read, synchronous clear.
module slave_mem #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] wr_idx_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [31:0]   rdata_c
);

    logic [31:0] mem_q [DEPTH];

    // Clear wins over a concurrent write so a reset never commits data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[wr_idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem_q[rd_idx_i];

endmodule

// File: rtl/slave_ahb.sv
// AHB-Lite memory slave with pipelined address/data phases and two-cycle ERROR responses.
// Optional wait states per data phase when SLAVE_WAIT_STATE_EN is defined.
module slave_ahb
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        CLK_SLAVE,
    input  logic        RESET_SLAVE,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
`ifdef SLAVE_WAIT_STATE_EN
    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);
`else
    localparam logic [2:0] WAIT_LD = 3'd0;
`endif

    slv_state_e    state_q, state_d;
    logic          hready_q, hready_d;
    logic          hresp_q, hresp_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
`ifdef SLAVE_WAIT_STATE_EN
    logic [2:0]    wcnt_q, wcnt_d;
`endif

    logic          sample_c;
    logic          legal_c;
    logic          mem_we_c;
    logic [3:0]    mem_be_c;
    logic [AW-1:0] rd_idx_c;
    logic [31:0]   mem_rdata_c;
    logic [31:0]   fwd_rdata_c;
    logic          unused_burst_c;

    // Burst type is accepted but addressing relies only on HADDR.
    assign unused_burst_c = ^HBURST;

    assign sample_c = hready_q && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign mem_we_c = (state_q == ST_DATA) && hready_q && write_q;
    assign mem_be_c = byte_en(size_q, addr_q[1:0]);
    // Read data is looked up one cycle ahead so HRDATA can be a register.
    assign rd_idx_c = (state_q == ST_WAIT) ? addr_q[AW+1:2] : HADDR[AW+1:2];

    always_comb begin
        legal_c = 1'b1;
        if (HSIZE > HSIZE_WORD)                             legal_c = 1'b0;
        if ((HSIZE == HSIZE_HALF) && HADDR[0])              legal_c = 1'b0;
        if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) legal_c = 1'b0;
        if (|HADDR[31:AW+2])                                legal_c = 1'b0;
    end

    // Bypass a write completing on the same edge a read of that word is sampled.
    always_comb begin
        fwd_rdata_c = mem_rdata_c;
        for (int b = 0; b < 4; b++) begin
            if (mem_we_c && mem_be_c[b] && (addr_q[AW+1:2] == rd_idx_c)) begin
                fwd_rdata_c[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        hrdata_d = hrdata_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
`ifdef SLAVE_WAIT_STATE_EN
        wcnt_d   = wcnt_q;
`endif
        case (state_q)
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = HRESP_ERROR;
            end
`ifdef SLAVE_WAIT_STATE_EN
            ST_WAIT: begin
                wcnt_d = wcnt_q - 3'd1;
                if (wcnt_q <= 3'd1) begin
                    state_d = ST_DATA;
                    if (!write_q) hrdata_d = fwd_rdata_c;
                end else begin
                    hready_d = 1'b0;
                end
            end
`endif
            // IDLE, DATA and ERR2 all present HREADY=1, so an address phase may be taken.
            default: begin
                if (!sample_c) begin
                    state_d = ST_IDLE;
                end else if (!legal_c) begin
                    state_d  = ST_ERR1;
                    hready_d = 1'b0;
                    hresp_d  = HRESP_ERROR;
                end else begin
                    addr_d  = HADDR[AW+1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
`ifdef SLAVE_WAIT_STATE_EN
                    wcnt_d  = WAIT_LD;
`endif
                    if (WAIT_LD != 3'd0) begin
                        state_d  = ST_WAIT;
                        hready_d = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                        if (!HWRITE) hrdata_d = fwd_rdata_c;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK_SLAVE) begin
        if (RESET_SLAVE) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            hrdata_q <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= HSIZE_BYTE;
`ifdef SLAVE_WAIT_STATE_EN
            wcnt_q   <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
`ifdef SLAVE_WAIT_STATE_EN
            wcnt_q   <= wcnt_d;
`endif
        end
    end

    slave_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i    (CLK_SLAVE),
        .rst_i    (RESET_SLAVE),
        .we_i     (mem_we_c),
        .be_i     (mem_be_c),
        .wr_idx_i (addr_q[AW+1:2]),
        .wdata_i  (HWDATA),
        .rd_idx_i (rd_idx_c),
        .rdata_c  (mem_rdata_c)
    );

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;
    assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_slave_ahb.sv
// Scoreboard bench for slave_ahb: a master-side driver queues expected responses, a monitor checks completions.
module tb_slave_ahb;
    import ahb_pkg::*;

`ifdef SLAVE_WAIT_STATE_EN
    localparam int unsigned TB_WAIT = 2;
    localparam int          EXPW    = 2;
`else
    localparam int unsigned TB_WAIT = 1;
    localparam int          EXPW    = 0;
`endif

    logic        CLK_SLAVE = 1'b0;
    logic        RESET_SLAVE;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    typedef struct {
        string       name;
        bit          rd;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    slave_ahb #(
        .MEM_DEPTH   (64),
        .WAIT_CYCLES (TB_WAIT)
    ) dut (
        .CLK_SLAVE   (CLK_SLAVE),
        .RESET_SLAVE (RESET_SLAVE),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    always #5 CLK_SLAVE = ~CLK_SLAVE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one address phase, hold it until accepted, then drive its write data.
    task automatic drive(input string name, input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] wd,
                         input bit push, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        exp_t e;
        if (push) begin
            e.name  = name;
            e.rd    = !w;
            e.rdata = exp_rd;
            e.resp  = exp_err;
            e.waits = exp_err ? 1 : EXPW;
            sb.push_back(e);
        end
        HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = tr; HBURST = bu;
        n = 0;
        do begin
            @(negedge CLK_SLAVE);
            n++;
        end while (!HREADY && n < 32);
        if (!HREADY) chk({name, "_accept_timeout"}, 32'(HREADY), 32'd1);
        @(posedge CLK_SLAVE);
        #1;
        HWDATA = wd;
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [2:0] sz,
                      input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] wd);
        drive(name, a, 1'b1, sz, tr, bu, wd, 1'b1, 32'h0, HRESP_OKAY);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [1:0] tr,
                      input logic [2:0] bu, input logic [31:0] exp);
        drive(name, a, 1'b0, HSIZE_WORD, tr, bu, 32'h0, 1'b1, exp, HRESP_OKAY);
    endtask

    task automatic bad(input string name, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        drive(name, a, 1'b1, sz, HTRANS_NONSEQ, HBURST_SINGLE, wd, 1'b1, 32'h0, HRESP_ERROR);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive("idle", 32'h0, 1'b0, HSIZE_WORD, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    // Monitor: tracks which cycles are data phases and checks each completion against the queue head.
    initial begin : monitor
        bit   dp_active;
        int   stall;
        exp_t e;
        dp_active = 1'b0;
        stall     = 0;
        forever begin
            @(negedge CLK_SLAVE);
            if (RESET_SLAVE) begin
                dp_active = 1'b0;
                stall     = 0;
            end else begin
                if (dp_active) begin
                    if (!HREADY) begin
                        stall++;
                        if (sb.size() > 0) chk({sb[0].name, "_stall_hresp"}, 32'(HRESP), 32'(sb[0].resp));
                    end else if (sb.size() == 0) begin
                        chk("unexpected_completion", 32'(sb.size()), 32'd1);
                        stall = 0;
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_hresp"}, 32'(HRESP), 32'(e.resp));
                        chk({e.name, "_waits"}, 32'(stall), 32'(e.waits));
                        if (e.rd && !e.resp) chk({e.name, "_hrdata"}, HRDATA, e.rdata);
                        stall = 0;
                    end
                end else begin
                    chk("idle_hresp", 32'(HRESP), 32'(HRESP_OKAY));
                end
                if (HREADY) dp_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        RESET_SLAVE = 1'b1;
        HADDR = 32'h0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HBURST = HBURST_SINGLE; HWDATA = 32'h0;
        repeat (3) @(posedge CLK_SLAVE);
        @(negedge CLK_SLAVE);
        chk("reset_hready", 32'(HREADY), 32'd1);
        chk("reset_hresp",  32'(HRESP),  32'd0);
        chk("reset_hrdata", HRDATA,      32'h0);
        @(posedge CLK_SLAVE);
        #1;
        RESET_SLAVE = 1'b0;

        // Word write then pipelined read of the same word.
        wr("wr08", 32'h08, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'hDEADBEEF);
        rd("rd08", 32'h08, HTRANS_NONSEQ, HBURST_SINGLE, 32'hDEADBEEF);
        idle(1);

        // Upper halfword write merges into the existing word.
        wr("half0a", 32'h0A, HSIZE_HALF, HTRANS_NONSEQ, HBURST_SINGLE, 32'h12345678);
        rd("rd08_half", 32'h08, HTRANS_NONSEQ, HBURST_SINGLE, 32'h1234BEEF);
        idle(1);

        // INCR4 write directly followed by INCR4 read.
        wr("incr_w10", 32'h10, HSIZE_WORD, HTRANS_NONSEQ, HBURST_INCR4, 32'h11);
        wr("incr_w14", 32'h14, HSIZE_WORD, HTRANS_SEQ,    HBURST_INCR4, 32'h22);
        wr("incr_w18", 32'h18, HSIZE_WORD, HTRANS_SEQ,    HBURST_INCR4, 32'h33);
        wr("incr_w1c", 32'h1C, HSIZE_WORD, HTRANS_SEQ,    HBURST_INCR4, 32'h44);
        rd("incr_r10", 32'h10, HTRANS_NONSEQ, HBURST_INCR4, 32'h11);
        rd("incr_r14", 32'h14, HTRANS_SEQ,    HBURST_INCR4, 32'h22);
        rd("incr_r18", 32'h18, HTRANS_SEQ,    HBURST_INCR4, 32'h33);
        rd("incr_r1c", 32'h1C, HTRANS_SEQ,    HBURST_INCR4, 32'h44);
        idle(1);

        // Byte write: only lane 1 of a replicated data bus may land.
        wr("byte05", 32'h05, HSIZE_BYTE, HTRANS_NONSEQ, HBURST_SINGLE, 32'hABABABAB);
        drive("busy", 32'h08, 1'b0, HSIZE_WORD, HTRANS_BUSY, HBURST_SINGLE, 32'h0, 1'b0, 32'h0, 1'b0);
        rd("rd04", 32'h04, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000AB00);
        idle(1);

        // Illegal transfers; the aliased words must stay untouched.
        bad("err_misalign", 32'h102, HSIZE_WORD, 32'hFFFFFFFF);
        bad("err_range",    32'h400, HSIZE_WORD, 32'hFFFFFFFF);
        bad("err_half",     32'h03,  HSIZE_HALF, 32'hFFFFFFFF);
        bad("err_size",     32'h0C,  3'b011,     32'hFFFFFFFF);
        rd("rd00_after_err", 32'h00, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0);
        rd("rd0c_after_err", 32'h0C, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0);
        rd("rd10_pre_rst",   32'h10, HTRANS_NONSEQ, HBURST_SINGLE, 32'h11);

        // Reset during a write data phase.
        drive("wr20_abort", 32'h20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'h12345678,
              1'b0, 32'h0, 1'b0);
        HTRANS = HTRANS_IDLE;
        RESET_SLAVE = 1'b1;
        @(negedge CLK_SLAVE);
        @(negedge CLK_SLAVE);
        chk("midrst_hready", 32'(HREADY), 32'd1);
        chk("midrst_hresp",  32'(HRESP),  32'd0);
        chk("midrst_hrdata", HRDATA,      32'h0);
        @(posedge CLK_SLAVE);
        #1;
        RESET_SLAVE = 1'b0;
        rd("rd20_post_rst", 32'h20, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0);
        rd("rd08_post_rst", 32'h08, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0);
        idle(3);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slave_ahb.md
SLAVE_AHB -- requirements
Module: slave_ahb

Interface
REQ-001 SHALL have parameter MEM_DEPTH, 64, number of 32-bit words in the internal memory (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, 1, wait states inserted per data phase when SLAVE_WAIT_STATE_EN is defined (range 0..7).
REQ-003 SHALL have port CLK_SLAVE  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_SLAVE  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port HADDR  input  32  transfer address.
REQ-006 SHALL have port HTRANS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 SHALL have port HWRITE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port HSIZE  input  3  000 byte, 001 halfword, 010 word.
REQ-009 SHALL have port HBURST  input  3  burst type; accepted, not decoded for addressing.
REQ-010 SHALL have port HWDATA  input  32  write data, valid in the data phase.
REQ-011 SHALL have port HREADY  output  1  1 = current data phase completes this cycle.
REQ-012 SHALL have port HRESP  output  1  0 = OKAY, 1 = ERROR.
REQ-013 SHALL have port HRDATA  output  32  read data, valid when HREADY=1 ending a read data phase.

Function
REQ-014 SHALL sample an address phase only when HREADY=1 and HTRANS is NONSEQ or SEQ, registering HADDR, HWRITE and HSIZE for the following data phase.
REQ-015 SHALL treat IDLE and BUSY as zero-wait OKAY, with no memory access.
REQ-016 SHALL use state machine IDLE, DATA, WAIT, ERR1, ERR2: IDLE->DATA on valid sample; DATA->WAIT if wait count >0; WAIT->DATA when count expires; DATA->DATA/IDLE on completion depending on the next sample; any->ERR1 on an illegal sample; ERR1->ERR2; ERR2->DATA/IDLE.
REQ-017 SHALL, in DATA with HREADY=1, write HWDATA into mem[addr[AW+1:2]] on that clock edge, enabling byte lanes from HSIZE and addr[1:0] (little-endian).
REQ-018 SHALL, for a read, drive HRDATA with the full addressed word in the cycle HREADY=1; HRDATA holds its last value otherwise.
REQ-019 SHALL support pipelining: the next address phase overlaps the current data phase, giving one transfer per cycle with zero waits; a write followed by a read of the same word returns the new data.
REQ-020 SHALL flag illegal transfers: word index >= MEM_DEPTH, HSIZE > 010, or misalignment (halfword addr[0]=1; word addr[1:0]!=0).
REQ-021 SHALL answer an illegal transfer with a two-cycle ERROR: ERR1 HREADY=0/HRESP=1, ERR2 HREADY=1/HRESP=1, with no memory write.
REQ-022 SHALL drive HRESP=0 in every non-error cycle.
REQ-023 SHALL take the wait counter width as 3 bits, loaded with WAIT_CYCLES on each sample, decremented in WAIT, with HREADY=0 throughout WAIT.

Reset
REQ-024 SHALL, while RESET_SLAVE=1 at a clock edge, force state IDLE, HREADY=1, HRESP=0, HRDATA=0, wait counter 0, and all memory words to 0.
REQ-025 SHALL abort any in-flight data phase on reset with no memory write committed.

Configuration
REQ-026 SHALL, with SLAVE_WAIT_STATE_EN defined, insert WAIT_CYCLES wait states (HREADY=0) before every non-error data phase completes.
REQ-027 SHALL, without SLAVE_WAIT_STATE_EN, compile out the WAIT state and counter; every legal data phase completes in one cycle.

Structure
REQ-028 SHALL place the HTRANS, HSIZE, HBURST and HRESP encodings and the state enumeration in shared package ahb_pkg, used by master_ahb as well.
REQ-029 SHALL implement storage in sub-module slave_mem (MEM_DEPTH x 32, byte-enable synchronous write, combinational read, synchronous clear).

Verification
REQ-030 SHALL cover: NONSEQ word write 0xDEADBEEF to 0x08, then read 0x08 -> HRDATA=0xDEADBEEF, HRESP=0.
REQ-031 SHALL cover: INCR4 write 0x11,0x22,0x33,0x44 to 0x10..0x1C, then INCR4 read -> the same data, four data phases back-to-back with zero waits.
REQ-032 SHALL cover: byte write 0xAB to 0x05 over word 0 -> reading 0x04 returns 0x0000AB00.
REQ-033 SHALL cover: word write to 0x102 (misaligned) and to 0x400 (out of range, MEM_DEPTH=64) -> two-cycle ERROR each, memory unchanged.
REQ-034 SHALL cover, with SLAVE_WAIT_STATE_EN and WAIT_CYCLES=2: word read -> HREADY low two cycles, then high with data.
REQ-035 SHALL cover: reset asserted during a write data phase -> write not committed; outputs at reset values the next cycle.
